// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
// Optional fetch-address fault check is enabled by defining FETCH_ADDR_CHECK_EN.
module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] IM_TOP     = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_target,
   input  logic        exc_req,
   input  logic        eret_req,
   input  logic [31:0] epc,
   output logic [31:0] PC,
   output logic [31:0] instr_D,
   output logic [31:0] PC_D,
   output logic [31:0] PC8_D,
   output logic        valid_D,
   output logic        bd_D,
   output logic [4:0]  excode_D
);

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;

   logic [31:0] pc_reg;
   logic [31:0] pc_next;
   logic [31:0] instr_d_reg;
   logic [31:0] pc_d_reg;
   logic        valid_d_reg;
   logic        bd_d_reg;
   logic [4:0]  excode_d_reg;
   logic        fetch_fault;

`ifdef FETCH_ADDR_CHECK_EN
   assign fetch_fault = (pc_reg[1:0] != 2'b00) || (pc_reg < RESET_PC) || (pc_reg > IM_TOP);
`else
   assign fetch_fault = 1'b0;
`endif

   // Redirects arriving during a stall are dropped; D re-presents them afterwards.
   always_comb begin
      pc_next = pc_reg + 32'd4;
      if (exc_req)
         pc_next = HANDLER_PC;
      else if (eret_req)
         pc_next = epc;
      else if (stall)
         pc_next = pc_reg;
      else if (redirect)
         pc_next = redirect_target;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pc_reg       <= RESET_PC;
         instr_d_reg  <= 32'd0;
         pc_d_reg     <= 32'd0;
         valid_d_reg  <= 1'b0;
         bd_d_reg     <= 1'b0;
         excode_d_reg <= EXC_NONE;
      end else begin
         pc_reg <= pc_next;
         if (exc_req || eret_req) begin
            instr_d_reg  <= 32'd0;
            pc_d_reg     <= 32'd0;
            valid_d_reg  <= 1'b0;
            bd_d_reg     <= 1'b0;
            excode_d_reg <= EXC_NONE;
         end else if (!stall) begin
            instr_d_reg  <= fetch_fault ? 32'd0 : instr;
            pc_d_reg     <= pc_reg;
            valid_d_reg  <= 1'b1;
            bd_d_reg     <= redirect;
            excode_d_reg <= fetch_fault ? EXC_ADEL : EXC_NONE;
         end
      end
   end

   assign PC       = pc_reg;
   assign instr_D  = instr_d_reg;
   assign PC_D     = pc_d_reg;
   assign PC8_D    = pc_d_reg + 32'd8;
   assign valid_D  = valid_d_reg;
   assign bd_D     = bd_d_reg;
   assign excode_D = excode_d_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random traffic against a cycle-level reference model.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] IM_TOP     = 32'h0000_6FFC;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic        stall;
   logic        redirect;
   logic [31:0] redirect_target;
   logic        exc_req;
   logic        eret_req;
   logic [31:0] epc;
   logic [31:0] PC;
   logic [31:0] instr_D;
   logic [31:0] PC_D;
   logic [31:0] PC8_D;
   logic        valid_D;
   logic        bd_D;
   logic [4:0]  excode_D;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [31:0] m_pc, m_instr, m_pcd;
   logic        m_valid, m_bd;
   logic [4:0]  m_exc;

   fetch_unit dut (
      .clk(clk), .reset(reset), .instr(instr), .stall(stall), .redirect(redirect),
      .redirect_target(redirect_target), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
      .PC(PC), .instr_D(instr_D), .PC_D(PC_D), .PC8_D(PC8_D), .valid_D(valid_D),
      .bd_D(bd_D), .excode_D(excode_D)
   );

   always #5 clk = ~clk;

   // instruction memory contents are a fixed hash of the word address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'hDEAD_BEEF;
   endfunction

   assign instr = mem_word(PC);

   function automatic logic is_fault(input logic [31:0] a);
`ifdef FETCH_ADDR_CHECK_EN
      return (a % 4 != 0) || (a < RESET_PC) || (a > IM_TOP);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_step();
      logic f;
      if (!reset) begin
         m_pc = RESET_PC; m_instr = 0; m_pcd = 0; m_valid = 0; m_bd = 0; m_exc = 0;
      end else if (exc_req || eret_req) begin
         m_pc = exc_req ? HANDLER_PC : epc;
         m_instr = 0; m_pcd = 0; m_valid = 0; m_bd = 0; m_exc = 0;
      end else if (!stall) begin
         f = is_fault(m_pc);
         m_instr = f ? 32'd0 : mem_word(m_pc);
         m_pcd   = m_pc;
         m_valid = 1'b1;
         m_bd    = redirect;
         m_exc   = f ? 5'd4 : 5'd0;
         m_pc    = redirect ? redirect_target : m_pc + 32'd4;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".PC"},       PC,              m_pc);
      check({tag, ".instr_D"},  instr_D,         m_instr);
      check({tag, ".PC_D"},     PC_D,            m_pcd);
      check({tag, ".PC8_D"},    PC8_D,           m_pcd + 32'd8);
      check({tag, ".valid_D"},  {31'd0, valid_D}, {31'd0, m_valid});
      check({tag, ".bd_D"},     {31'd0, bd_D},    {31'd0, m_bd});
      check({tag, ".excode_D"}, {27'd0, excode_D}, {27'd0, m_exc});
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
      $display("cyc %s: PC=%h PC_D=%h instr_D=%h v=%0b bd=%0b exc=%0d",
               tag, PC, PC_D, instr_D, valid_D, bd_D, excode_D);
      @(negedge clk);
   endtask

   task automatic idle();
      reset = 1; stall = 0; redirect = 0; exc_req = 0; eret_req = 0;
   endtask

   logic [4:0] exp_adel;

   initial begin
`ifdef FETCH_ADDR_CHECK_EN
      exp_adel = 5'd4;
`else
      exp_adel = 5'd0;
`endif
      m_pc = 0; m_instr = 0; m_pcd = 0; m_valid = 0; m_bd = 0; m_exc = 0;
      idle(); redirect_target = 0; epc = 0;
      reset = 0;
      cycle("reset0");
      cycle("reset1");
      check("rst_pc", PC, 32'h3000);
      check("rst_pc8", PC8_D, 32'd8);
      check("rst_valid", {31'd0, valid_D}, 32'd0);

      idle();
      cycle("seq0");
      check("seq0_pc", PC, 32'h3004);
      check("seq0_pcd", PC_D, 32'h3000);
      cycle("seq1");
      check("seq1_pc", PC, 32'h3008);

      redirect = 1; redirect_target = 32'h3100;
      cycle("redir");
      check("redir_pc", PC, 32'h3100);
      check("redir_pcd", PC_D, 32'h3008);
      check("redir_bd", {31'd0, bd_D}, 32'd1);
      redirect = 0;
      cycle("after_redir");
      check("ar_pcd", PC_D, 32'h3100);
      check("ar_bd", {31'd0, bd_D}, 32'd0);

      redirect = 1; redirect_target = 32'h3010;
      cycle("to3010");
      redirect = 0; stall = 1;
      for (int i = 0; i < 3; i++) begin
         cycle("stall");
         check("stall_pc", PC, 32'h3010);
      end
      stall = 0;
      cycle("unstall");
      check("unstall_pc", PC, 32'h3014);

      redirect = 1; redirect_target = 32'h3020;
      cycle("to3020");
      redirect = 0; exc_req = 1; stall = 1;
      cycle("exc");
      check("exc_pc", PC, 32'h4180);
      check("exc_instr", instr_D, 32'd0);
      exc_req = 0; stall = 0; eret_req = 1; epc = 32'h3024;
      cycle("eret");
      check("eret_pc", PC, 32'h3024);
      check("eret_valid", {31'd0, valid_D}, 32'd0);
      eret_req = 0;

      redirect = 1; redirect_target = 32'h3002;
      cycle("to3002");
      redirect = 0;
      cycle("fault_align");
      check("fa_pcd", PC_D, 32'h3002);
      check("fa_exc", {27'd0, excode_D}, {27'd0, exp_adel});
      redirect = 1; redirect_target = 32'h7000;
      cycle("to7000");
      redirect = 0;
      cycle("fault_range");
      check("fr_pcd", PC_D, 32'h7000);
      check("fr_exc", {27'd0, excode_D}, {27'd0, exp_adel});

      reset = 0; stall = 1; redirect = 1; redirect_target = 32'h3500;
      cycle("rst_stall0");
      cycle("rst_stall1");
      check("rs_pc", PC, 32'h3000);
      idle();
      cycle("rs_release");
      check("rsr_pc", PC, 32'h3004);
      check("rsr_bd", {31'd0, bd_D}, 32'd0);

      for (int i = 0; i < 400; i++) begin
         reset    = ($urandom_range(0, 99) != 0);
         stall    = ($urandom_range(0, 3) == 0);
         redirect = ($urandom_range(0, 4) == 0);
         exc_req  = ($urandom_range(0, 29) == 0);
         eret_req = ($urandom_range(0, 24) == 0);
         redirect_target = RESET_PC + ($urandom_range(0, 4200) << 2);
         if ($urandom_range(0, 7) == 0)
            redirect_target = redirect_target + $urandom_range(1, 3);
         epc = RESET_PC + ($urandom_range(0, 4095) << 2);
         cycle("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
